// File: rtl/pyfive_wb_pkg.sv
// Shared types for the PyFive two-master Wishbone arbiter: FSM encoding and
// the master request bundle that the top muxes onto the slave port.
package pyfive_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '0;

endpackage

// File: rtl/pyfive_wb_watchdog.sv
// Stall watchdog: counts unacknowledged strobe cycles and flags expiry when
// the count reaches TIMEOUT_CYCLES. Clear has priority over enable.
module pyfive_wb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Hold at the limit so the counter never wraps back to a non-expired value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/pyfive_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the PyFive slave port.
// Grant is held for a whole cyc; a watchdog ends stalled strobes with err.
module pyfive_wb_arbiter
    import pyfive_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  grant_o
);

    wb_req_t     req [2];
    wb_req_t     own_req;
    arb_state_t  state_q;
    logic        ptr_q;
    logic [1:0]  grant_q;
    logic        expired;
    logic [1:0]  ack_m;
    logic [1:0]  err_m;
    logic [31:0] dat_m [2];

    assign req[0] = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
    assign req[1] = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};

    always_comb begin
        own_req = WB_REQ_IDLE;
        if (grant_q[0]) begin
            own_req = req[0];
        end else if (grant_q[1]) begin
            own_req = req[1];
        end
    end

    pyfive_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (wb_clk_i),
        .srst_i   (wb_rst_i),
        .clr_i    ((grant_q == 2'b00) | s_ack_i | ~own_req.stb),
        .en_i     (own_req.stb & ~s_ack_i),
        .expired_o(expired)
    );

    // ptr_q names the last winner, so a tie goes to the other master.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b1;
            grant_q <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req[0].cyc && (!req[1].cyc || ptr_q)) begin
                        state_q <= ST_OWN0;
                        ptr_q   <= 1'b0;
                        grant_q <= 2'b01;
                    end else if (req[1].cyc) begin
                        state_q <= ST_OWN1;
                        ptr_q   <= 1'b1;
                        grant_q <= 2'b10;
                    end
                end
                ST_OWN0: begin
                    if (!req[0].cyc || expired) begin
                        state_q <= ST_IDLE;
                        grant_q <= 2'b00;
                    end
                end
                ST_OWN1: begin
                    if (!req[1].cyc || expired) begin
                        state_q <= ST_IDLE;
                        grant_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    // On the expiry cycle err replaces ack and the slave sees the cycle end.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            assign ack_m[gi] = grant_q[gi] & own_req.stb & s_ack_i & ~expired;
            assign err_m[gi] = grant_q[gi] & expired;
            assign dat_m[gi] = grant_q[gi] ? s_dat_i : 32'h0;
        end
    endgenerate

    assign m0_ack_o = ack_m[0];
    assign m0_err_o = err_m[0];
    assign m0_dat_o = dat_m[0];
    assign m1_ack_o = ack_m[1];
    assign m1_err_o = err_m[1];
    assign m1_dat_o = dat_m[1];

    assign s_cyc_o = own_req.cyc & ~expired;
    assign s_stb_o = own_req.stb & ~expired;
    assign s_we_o  = own_req.we;
    assign s_sel_o = own_req.sel;
    assign s_adr_o = own_req.adr;
    assign s_dat_o = own_req.dat;
    assign grant_o = grant_q;

endmodule

// File: doc/pyfive_wb_arbiter.md
# pyfive_wb_arbiter

Two-master Wishbone arbiter that shares the single slave port of the PyFive user-project core between the Caravel management SoC (master 0) and an on-chip debug/DMA bridge (master 1). It grants one master at a time, holds the grant for the whole bus cycle (`cyc`), and rotates priority round-robin. A watchdog ends any stalled access with an error, so neither master can hang the bus. It sits between the Caravel Wishbone interconnect and the user-project slave inside the user-project wrapper.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles a granted strobe may wait for slave ack before the arbiter ends it with an error; legal range 1..65535.
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 Wishbone controls.
- `m0_sel_i`  in  4  master 0 byte selects.
- `m0_adr_i`, `m0_dat_i`  in  32 each  master 0 address and write data.
- `m0_ack_o`, `m0_err_o`  out  1 each  master 0 ack and error.
- `m0_dat_o`  out  32  master 0 read data.
- `m1_*`  same set as `m0_*`, for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave controls.
- `s_sel_o`  out  4  slave byte selects.
- `s_adr_o`, `s_dat_o`  out  32 each  slave address and write data.
- `s_ack_i`  in  1  slave ack.
- `s_dat_i`  in  32  slave read data.
- `grant_o`  out  2  one-hot current owner (debug/status); 2'b00 when idle.

## Operation
- FSM has 3 states: IDLE, OWN0, OWN1. Reset state is IDLE, and the last-grant pointer resets to 1, so master 0 wins the first tie.
- A master requests when its `cyc` is high.
- IDLE, one requester: go to that master's OWN state next cycle.
- IDLE, both requesting: grant the master that is not the last-grant pointer. The pointer updates to the winner on grant.
- OWNx forwarding: slave `cyc/stb/we/sel/adr/dat` come from master x combinationally. Slave `ack` and `dat` return to master x only.
- Non-owner, and all masters in IDLE: `ack`, `err` and `dat_o` read 0. Slave `cyc/stb` are 0 in IDLE.
- OWNx ends, returning to IDLE next cycle, when either:
  - `mx_cyc_i` falls. Owner deasserting `cyc` in the same cycle as `ack` is legal: `ack` is still delivered.
  - The watchdog fires.
- Watchdog: a counter of width ceil(log2(TIMEOUT_CYCLES+1)).
  - Clears in IDLE, on every `s_ack_i`, and whenever the owner's `stb` is low.
  - Increments while the owner's `stb` is high and `s_ack_i` is low.
  - When it reaches TIMEOUT_CYCLES: pulse `mx_err_o` for exactly that cycle, force slave `cyc/stb` low in that cycle, then return to IDLE.
  - After a timeout the pointer already names x, so any waiting peer wins the next arbitration.
- `s_ack_i` while IDLE or while owner `stb` is low: ignored and not forwarded.
- `err` and `ack` are never high together. On the timeout cycle, `err` wins and `ack` is suppressed.
- Reset mid-transfer: next cycle the FSM is IDLE, slave `cyc/stb` are 0, all master outputs are 0, and the pointer is back to 1.

## Timing
- Arbitration latency: 1 cycle from `cyc` rising in IDLE to the slave seeing `cyc/stb`.
- After ownership: forward and return paths are combinational, with no added latency per beat. Pipelined back-to-back beats under one `cyc` pass at the slave's own rate.
- Handover: at least 1 idle cycle (IDLE state) between owners.
- Timeout: `err` is asserted on the cycle in which the counter equals TIMEOUT_CYCLES, i.e. the (TIMEOUT_CYCLES+1)th cycle of unacknowledged `stb`.
- Reset values:
  - `grant_o` = 0.
  - All `s_*` outputs = 0.
  - All `m*_ack_o`, `m*_err_o`, `m*_dat_o` = 0.

## Structure
- Shared package `pyfive_wb_pkg`: FSM state encoding (IDLE/OWN0/OWN1) and a Wishbone master-request bundle typedef (`cyc`, `stb`, `we`, `sel`, `adr`, `dat`).
- One sub-module, `pyfive_wb_watchdog`: counter, clear/enable inputs, `expired` output, parameterised by TIMEOUT_CYCLES.
- Everything else (FSM, round-robin pointer, muxes) lives in the top module.

## Test plan
- **Solo read:** m0 reads 0x3000_0004; slave acks after 2 cycles with 0xA5A5_0001.
  - `m0_ack_o` high in exactly that cycle with `m0_dat_o` = 0xA5A5_0001.
  - `grant_o` = 01 one cycle after `cyc`.
- **Tie after reset:** both raise `cyc` in the same cycle.
  - m0 is granted first; m1 is granted after m0 drops `cyc` plus 1 idle cycle.
  - The next simultaneous tie goes to m0 again, since the pointer now names m1.
- **Round-robin fairness:** both hold requests continuously over 6 single-beat cycles.
  - Grants alternate m0, m1, m0, m1, m0, m1.
  - `m1_ack_o` and `m1_dat_o` stay 0 throughout m0's ownership.
- **Timeout:** TIMEOUT_CYCLES=4; m1 strobes and the slave never acks.
  - `m1_err_o` pulses on the 5th `stb` cycle, with slave `cyc` = 0 in that cycle.
  - FSM returns to IDLE; a pending m0 is granted next.
- **Block transfer:** m0 holds `cyc` over 4 beats.
  - No re-arbitration occurs, even with m1 requesting throughout.
  - The watchdog clears on every ack.
- **Reset mid-beat:** assert `wb_rst_i` during OWN1 with `stb` high.
  - Next cycle all outputs are 0, `grant_o` = 00, and the following tie is granted to m0.
